alu_ctrl_mdu: RTL and testbench

//  Registered, parametrised ALU control for the EX stage. It decodes ALUOp plus funct into the ALU

---
 rtl/alu_ctrl_mdu.sv | 201 ++++++++++++++++++++
 tb/tb_alu_ctrl_mdu.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_mdu.sv
// EX-stage ALU control: registered funct/ALUOp decode plus an iterative unsigned
// multiply/divide unit that owns HI/LO and stalls upstream while it runs.
//
// state  | meaning
// S_IDLE | decode requests accepted, in_ready high
// S_RUN  | MDU iterating, one step per cycle for XLEN cycles
module alu_ctrl_mdu #(
    parameter int XLEN = 32,
    parameter int FW   = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      fctrl,
    input  logic [5:0]      opr,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [FW-1:0]   func,
    output logic            out_valid,
    output logic [1:0]      wb_sel,
    output logic            illegal,
    output logic            busy,
    output logic            mdu_done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);
    localparam int CW = $clog2(XLEN);

    localparam logic [2:0] F_ADD  = 3'd0;
    localparam logic [2:0] F_SUB  = 3'd1;
    localparam logic [2:0] F_AND  = 3'd2;
    localparam logic [2:0] F_OR   = 3'd3;
    localparam logic [2:0] F_NOR  = 3'd4;
    localparam logic [2:0] F_SLT  = 3'd5;
    localparam logic [2:0] F_XOR  = 3'd6;
    localparam logic [2:0] F_SLTU = 3'd7;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            div_q, div_d;
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0] upper_q, upper_d;
    logic [XLEN-1:0] lower_q, lower_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [FW-1:0]   func_q, func_d;
    logic [1:0]      wb_q, wb_d;
    logic            ov_q, ov_d;
    logic            ill_q, ill_d;
    logic            done_q, done_d;

    logic [2:0]      dec_code;
    logic [1:0]      dec_wb;
    logic            dec_ill, dec_mdu, dec_div, accept;

    logic [XLEN:0]   mul_sum, div_shift;
    logic            div_ge;
    logic [XLEN-1:0] step_upper, step_lower;

    always_comb begin
        dec_code = F_ADD;
        dec_wb   = 2'b00;
        dec_ill  = 1'b0;
        dec_mdu  = 1'b0;
        dec_div  = 1'b0;
        case (fctrl)
            2'b00: dec_code = F_ADD;
            2'b01: dec_code = F_SUB;
            2'b11: dec_code = F_AND;
            default: begin
                case (opr)
                    6'b100000, 6'b100001: dec_code = F_ADD;
                    6'b100010, 6'b100011: dec_code = F_SUB;
                    6'b100100: dec_code = F_AND;
                    6'b100101: dec_code = F_OR;
                    6'b100110: dec_code = F_XOR;
                    6'b100111: dec_code = F_NOR;
                    6'b101010: dec_code = F_SLT;
                    6'b101011: dec_code = F_SLTU;
                    6'b010000: dec_wb   = 2'b01;
                    6'b010010: dec_wb   = 2'b10;
                    6'b011001: dec_mdu  = 1'b1;
                    6'b011011: begin
                        dec_mdu = 1'b1;
                        dec_div = 1'b1;
                    end
                    default: dec_ill = 1'b1;
                endcase
            end
        endcase
    end

    assign accept = in_valid && (state_q == S_IDLE);

    // Multiply keeps {upper,lower} as the shifting product with the multiplier in lower;
    // divide keeps the partial remainder in upper and shifts quotient bits into lower.
    always_comb begin
        mul_sum   = {1'b0, upper_q} + (lower_q[0] ? {1'b0, mcand_q} : '0);
        div_shift = {upper_q, lower_q[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, mcand_q});
        if (div_q) begin
            step_upper = div_ge ? XLEN'(div_shift - {1'b0, mcand_q}) : div_shift[XLEN-1:0];
            step_lower = {lower_q[XLEN-2:0], div_ge};
        end else begin
            step_upper = mul_sum[XLEN:1];
            step_lower = {mul_sum[0], lower_q[XLEN-1:1]};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        mcand_d = mcand_q;
        upper_d = upper_q;
        lower_d = lower_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        func_d  = func_q;
        wb_d    = wb_q;
        ov_d    = 1'b0;
        ill_d   = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept && dec_mdu) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    div_d   = dec_div;
                    upper_d = '0;
                    lower_d = dec_div ? a : b;
                    mcand_d = dec_div ? b : a;
                end else if (accept) begin
                    func_d = FW'(dec_code);
                    wb_d   = dec_wb;
                    ov_d   = 1'b1;
                    ill_d  = dec_ill;
                end
            end
            S_RUN: begin
                upper_d = step_upper;
                lower_d = step_lower;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(XLEN - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    hi_d    = step_upper;
                    lo_d    = step_lower;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            mcand_q <= '0;
            upper_q <= '0;
            lower_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            func_q  <= '0;
            wb_q    <= 2'b00;
            ov_q    <= 1'b0;
            ill_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            mcand_q <= mcand_d;
            upper_q <= upper_d;
            lower_q <= lower_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            func_q  <= func_d;
            wb_q    <= wb_d;
            ov_q    <= ov_d;
            ill_q   <= ill_d;
            done_q  <= done_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q == S_RUN);
    assign func      = func_q;
    assign wb_sel    = wb_q;
    assign out_valid = ov_q;
    assign illegal   = ill_q;
    assign mdu_done  = done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// Scoreboard bench for alu_ctrl_mdu: driver pushes expected responses from a
// plain-arithmetic reference model, a negedge monitor pops and compares.
module tb_alu_ctrl_mdu;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] fctrl = 2'b00;
    logic [5:0] opr = 6'd0;
    logic [7:0] a = 8'd0, b = 8'd0;
    logic [2:0] func;
    logic       out_valid, illegal, busy, mdu_done;
    logic [1:0] wb_sel;
    logic [7:0] hi, lo;

    logic        w_in_valid = 1'b0;
    logic        w_in_ready;
    logic [31:0] w_a = 32'd0, w_b = 32'd0;
    logic [2:0]  w_func;
    logic        w_out_valid, w_illegal, w_busy, w_done;
    logic [1:0]  w_wb_sel;
    logic [31:0] w_hi, w_lo;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic       is_mdu;
        logic [2:0] func;
        logic [1:0] wb;
        logic       ill;
        logic [7:0] hi;
        logic [7:0] lo;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] exp_hi = 8'd0, exp_lo = 8'd0;

    alu_ctrl_mdu #(.XLEN(8), .FW(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .fctrl(fctrl), .opr(opr), .a(a), .b(b), .func(func), .out_valid(out_valid),
        .wb_sel(wb_sel), .illegal(illegal), .busy(busy), .mdu_done(mdu_done),
        .hi(hi), .lo(lo)
    );

    alu_ctrl_mdu #(.XLEN(32), .FW(3)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .fctrl(2'b10), .opr(6'b011001), .a(w_a), .b(w_b), .func(w_func),
        .out_valid(w_out_valid), .wb_sel(w_wb_sel), .illegal(w_illegal), .busy(w_busy),
        .mdu_done(w_done), .hi(w_hi), .lo(w_lo)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [1:0] fc, input logic [5:0] op,
                                   input logic [7:0] av, input logic [7:0] bv);
        exp_t e;
        logic [15:0] p;
        e.is_mdu = 1'b0; e.func = 3'd0; e.wb = 2'b00; e.ill = 1'b0; e.hi = 8'd0; e.lo = 8'd0;
        p = 16'(av) * 16'(bv);
        if (fc == 2'b01) e.func = 3'd1;
        else if (fc == 2'b11) e.func = 3'd2;
        else if (fc == 2'b10) begin
            case (op)
                6'h20, 6'h21: e.func = 3'd0;
                6'h22, 6'h23: e.func = 3'd1;
                6'h24: e.func = 3'd2;
                6'h25: e.func = 3'd3;
                6'h26: e.func = 3'd6;
                6'h27: e.func = 3'd4;
                6'h2A: e.func = 3'd5;
                6'h2B: e.func = 3'd7;
                6'h10: e.wb = 2'b01;
                6'h12: e.wb = 2'b10;
                6'h19: begin e.is_mdu = 1'b1; e.hi = p[15:8]; e.lo = p[7:0]; end
                6'h1B: begin
                    e.is_mdu = 1'b1;
                    e.lo = (bv == 0) ? 8'hFF : av / bv;
                    e.hi = (bv == 0) ? av : av % bv;
                end
                default: e.ill = 1'b1;
            endcase
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid || mdu_done) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_output out_valid=%b mdu_done=%b, required none", out_valid, mdu_done);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (e.is_mdu) begin
                        if (!mdu_done || out_valid || hi !== e.hi || lo !== e.lo) begin
                            bad++;
                            $display("FAIL mdu_result done=%b ov=%b hi=%h lo=%h, required done=1 ov=0 hi=%h lo=%h",
                                     mdu_done, out_valid, hi, lo, e.hi, e.lo);
                        end
                        exp_hi = e.hi;
                        exp_lo = e.lo;
                    end else if (!out_valid || mdu_done || func !== e.func || wb_sel !== e.wb || illegal !== e.ill) begin
                        bad++;
                        $display("FAIL decode ov=%b done=%b func=%0d wb=%b ill=%b, required ov=1 done=0 func=%0d wb=%b ill=%b",
                                 out_valid, mdu_done, func, wb_sel, illegal, e.func, e.wb, e.ill);
                    end
                end
            end else if (busy) begin
                total++;
                if (hi !== exp_hi || lo !== exp_lo) begin
                    bad++;
                    $display("FAIL hilo_hold hi=%h lo=%h, required hi=%h lo=%h", hi, lo, exp_hi, exp_lo);
                end
            end
        end
    end

    task automatic send(input logic [1:0] fc, input logic [5:0] op, input logic [7:0] av,
                        input logic [7:0] bv, output int waited);
        fctrl = fc; opr = op; a = av; b = bv; in_valid = 1'b1;
        waited = 0;
        while (!in_ready && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL accept_timeout in_ready=%b, required 1", in_ready);
            in_valid = 1'b0;
        end else begin
            sb.push_back(model(fc, op, av, bv));
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic check_busy_len(input int req);
        int n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (n != req) begin
            bad++;
            $display("FAIL busy_len got=%0d, required %0d", n, req);
        end
    endtask

    task automatic issue(input logic [1:0] fc, input logic [5:0] op, input logic [7:0] av, input logic [7:0] bv);
        int w;
        exp_t e;
        e = model(fc, op, av, bv);
        send(fc, op, av, bv, w);
        if (e.is_mdu) check_busy_len(8);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d, required 0", sb.size());
        end
    endtask

    logic [5:0] legal_ops [12] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                   6'h26, 6'h27, 6'h2A, 6'h2B, 6'h10, 6'h12};

    initial begin
        int w, n;
        #12 rst_n = 1'b1;
        @(posedge clk); #1;

        total++;
        if ({func, out_valid, wb_sel, illegal, busy, mdu_done, hi, lo} !== 25'd0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_state func=%0d ov=%b wb=%b ill=%b busy=%b done=%b hi=%h lo=%h rdy=%b, required zeros rdy=1",
                     func, out_valid, wb_sel, illegal, busy, mdu_done, hi, lo, in_ready);
        end

        // back-to-back decode of every table entry plus an unknown funct
        send(2'b00, 6'h3F, 8'd0, 8'd0, w);
        send(2'b01, 6'h00, 8'd0, 8'd0, w);
        send(2'b11, 6'h2A, 8'd0, 8'd0, w);
        for (int i = 0; i < 12; i++) send(2'b10, legal_ops[i], 8'd0, 8'd0, w);
        send(2'b10, 6'h3F, 8'd0, 8'd0, w);
        drain();

        issue(2'b10, 6'h19, 8'hFF, 8'hFF);
        issue(2'b10, 6'h12, 8'd0, 8'd0);
        drain();
        issue(2'b10, 6'h1B, 8'd200, 8'd7);
        issue(2'b10, 6'h10, 8'd0, 8'd0);
        issue(2'b10, 6'h1B, 8'd9, 8'd0);
        drain();

        // add held while busy: accepted on the first ready cycle
        send(2'b10, 6'h19, 8'd13, 8'd11, w);
        send(2'b00, 6'h00, 8'd0, 8'd0, w);
        total++;
        if (w != 8) begin
            bad++;
            $display("FAIL held_accept waited=%0d, required 8", w);
        end
        drain();

        // reset during RUN cycle 4
        send(2'b10, 6'h19, 8'hAB, 8'hCD, w);
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        sb.delete();
        exp_hi = 8'd0; exp_lo = 8'd0;
        total++;
        if ({func, out_valid, wb_sel, illegal, busy, mdu_done, hi, lo} !== 25'd0) begin
            bad++;
            $display("FAIL reset_midop func=%0d ov=%b wb=%b ill=%b busy=%b done=%b hi=%h lo=%h, required zeros",
                     func, out_valid, wb_sel, illegal, busy, mdu_done, hi, lo);
        end
        @(negedge clk); rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (mdu_done) n++;
        end
        total++;
        if (n != 0) begin
            bad++;
            $display("FAIL reset_abort mdu_done_count=%0d, required 0", n);
        end

        for (int i = 0; i < 60; i++) begin
            logic [1:0] fc;
            logic [5:0] op;
            int r;
            r = int'($urandom_range(0, 9));
            fc = (r < 6) ? 2'b10 : 2'($urandom_range(0, 3));
            if (r < 3) op = legal_ops[$urandom_range(0, 11)];
            else if (r < 5) op = ($urandom_range(0, 1) == 0) ? 6'h19 : 6'h1B;
            else op = 6'($urandom_range(0, 63));
            issue(fc, op, 8'($urandom), ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom));
        end
        drain();

        // 32-bit instance
        w_a = 32'hFFFF_FFFF; w_b = 32'd2; w_in_valid = 1'b1;
        @(posedge clk); #1;
        w_in_valid = 1'b0;
        n = 0;
        while (!w_done && n < 200) begin
            if (w_busy) n++;
            @(posedge clk); #1;
        end
        total++;
        if (n != 32 || !w_done || w_hi !== 32'd1 || w_lo !== 32'hFFFF_FFFE) begin
            bad++;
            $display("FAIL mul32 busy=%0d done=%b hi=%h lo=%h, required busy=32 done=1 hi=00000001 lo=fffffffe",
                     n, w_done, w_hi, w_lo);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
